motor_pwm_drv: RTL

Single-channel H-bridge motor driver stage for the two-wheel platform, instantiated once per wheel. It sits directly upstream of the motor pins (`Mta`/`ENa`, `Mtb`/`ENb`) and downstream of the CPU peripheral register interface. It turns a period/duty/direction command into a PWM enable plus direction pair. Commands are applied glitch-free at period boundaries, and a dead interval is inserted on every reversal.

---
 rtl/motor_pwm_drv.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/motor_pwm_drv.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_drv
// Purpose  : H-bridge PWM stage. Shadowed period/duty/direction commands are
//            applied at period wraps, with a coast interval on every reversal.
// Revision : 1.0 - initial release
// ============================================================================
module motor_pwm_drv #(
    parameter int CNT_W      = 10,
    parameter int PRESC_DIV  = 4,
    parameter int DEAD_TICKS = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [CNT_W-1:0] Period,
    input  logic [CNT_W-1:0] Duty,
    input  logic [1:0]       Dir,
    input  logic             Load,
    output logic             Busy,
    output logic             PrdEnd,
    output logic [1:0]       Mt,
    output logic             EN
);

    localparam int PSC_W  = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int DCNT_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [PSC_W-1:0]  c_psc_last  = PSC_W'(PRESC_DIV - 1);
    localparam logic [DCNT_W-1:0] c_dead_last = DCNT_W'(DEAD_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0]  prd_a_q, prd_a_d, duty_a_q, duty_a_d;
    logic [1:0]        dir_a_q, dir_a_d;
    logic [CNT_W-1:0]  prd_s_q, prd_s_d, duty_s_q, duty_s_d;
    logic [1:0]        dir_s_q, dir_s_d;
    logic              pend_q, pend_d;
    logic [1:0]        mt_q, mt_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              prdend_q, prdend_d;

    logic              w_tick;
    logic              w_wrap;
    logic              w_apply;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dcnt_d   = dcnt_q;
        prd_a_d  = prd_a_q;
        duty_a_d = duty_a_q;
        dir_a_d  = dir_a_q;
        prd_s_d  = prd_s_q;
        duty_s_d = duty_s_q;
        dir_s_d  = dir_s_q;
        pend_d   = pend_q;
        w_wrap   = 1'b0;
        w_apply  = 1'b0;

        w_tick = (psc_q == c_psc_last);
        psc_d  = w_tick ? '0 : psc_q + PSC_W'(1);

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                dcnt_d = '0;
                if (pend_q) begin
                    w_apply = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tick) begin
                    if (cnt_q == prd_a_q) begin
                        w_wrap = 1'b1;
                        cnt_d  = '0;
                        if (pend_q) begin
                            w_apply = 1'b1;
                            // Only a change away from an active drive direction needs coasting.
                            if ((dir_s_q != dir_a_q) && (dir_a_q[0] ^ dir_a_q[1])) begin
                                state_d = ST_DEAD;
                                dcnt_d  = '0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DEAD: begin
                cnt_d = '0;
                if (w_tick) begin
                    if (dcnt_q == c_dead_last) begin
                        state_d = ST_RUN;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                dcnt_d  = '0;
            end
        endcase

        if (w_apply) begin
            prd_a_d  = prd_s_q;
            duty_a_d = duty_s_q;
            dir_a_d  = dir_s_q;
            pend_d   = 1'b0;
        end

        // A strobe coinciding with an apply becomes the next pending command.
        if (Load) begin
            prd_s_d  = Period;
            duty_s_d = Duty;
            dir_s_d  = Dir;
            pend_d   = 1'b1;
        end

        mt_d = 2'b00;
        en_d = 1'b0;
        if (state_d == ST_RUN) begin
            mt_d = dir_a_d;
            case (dir_a_d)
                2'b00:   en_d = 1'b0;
                2'b11:   en_d = 1'b1;
                default: en_d = (cnt_d < duty_a_d);
            endcase
        end
        prdend_d = w_wrap;
        busy_d   = pend_d | (state_d == ST_DEAD);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            psc_q    <= '0;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            prd_a_q  <= '0;
            duty_a_q <= '0;
            dir_a_q  <= 2'b00;
            prd_s_q  <= '0;
            duty_s_q <= '0;
            dir_s_q  <= 2'b00;
            pend_q   <= 1'b0;
            mt_q     <= 2'b00;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            prdend_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            psc_q    <= psc_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
            prd_a_q  <= prd_a_d;
            duty_a_q <= duty_a_d;
            dir_a_q  <= dir_a_d;
            prd_s_q  <= prd_s_d;
            duty_s_q <= duty_s_d;
            dir_s_q  <= dir_s_d;
            pend_q   <= pend_d;
            mt_q     <= mt_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            prdend_q <= prdend_d;
        end
    end

    assign Mt     = mt_q;
    assign EN     = en_q;
    assign Busy   = busy_q;
    assign PrdEnd = prdend_q;

endmodule
`default_nettype wire
